// File: rtl/ipv4_rx.sv
// IPv4 receive parser: validates a fixed 20-byte header, then streams the payload one cycle after input.
// No backpressure: the stream cannot be stalled, so rejected or truncated frames are reported on kill.
module ipv4_rx #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] axiid,
  input  logic         axiiv,
  output logic [N-1:0] axiod,
  output logic         axiov,
  output logic [31:0]  src_ip_out,
  output logic [31:0]  dst_ip_out,
  output logic [7:0]   protocol_out,
  output logic [15:0]  packet_length_out,
  output logic         kill
);

  localparam int HB  = 160 / N;
  localparam int WPB = 16 / N;
  localparam int WB  = $clog2(WPB);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DROP} state_t;

  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [7:0]  tos;
    logic [15:0] total_len;
    logic [15:0] id;
    logic [2:0]  flags;
    logic [12:0] frag_off;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] csum;
    logic [31:0] src;
    logic [31:0] dst;
  } hdr_t;

  state_t         state;
  logic [159-N:0] hdr;
  logic [6:0]     cnt;
  logic [15:0]    acc;
  logic [19:0]    pay_left;
  logic           prev_vld;

  hdr_t        hdr_nxt;
  logic [16:0] sum;
  logic [15:0] acc_nxt;
  logic [15:0] plen;
  logic [19:0] beats;
  logic        word_end;
  logic        last_hdr;
  logic        hdr_ok;
  logic        hdr_beat;

  // The shift register plus the current beat is the complete header on the last beat.
  assign hdr_nxt  = {hdr, axiid};
  assign sum      = {1'b0, acc} + {1'b0, hdr_nxt[15:0]};
  assign acc_nxt  = sum[15:0] + {15'd0, sum[16]};
  assign word_end = &cnt[WB-1:0];
  assign last_hdr = (cnt == 7'(HB - 1));
  assign plen     = hdr_nxt.total_len - 16'd20;
  assign beats    = (N == 4) ? {3'd0, plen, 1'b0} : {2'd0, plen, 2'b00};

  assign hdr_ok = (hdr_nxt.version == 4'd4) && (hdr_nxt.ihl == 4'd5) &&
                  !hdr_nxt.flags[0] && (hdr_nxt.frag_off == 13'd0) &&
                  (hdr_nxt.total_len >= 16'd20) && (acc_nxt == 16'hFFFF);

  // A frame only starts on a rising valid, so a frame cut by reset is not re-parsed mid-stream.
  assign hdr_beat = axiiv && ((state == HEADER) || (state == IDLE && !prev_vld));

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      hdr               <= '0;
      cnt               <= '0;
      acc               <= '0;
      pay_left          <= '0;
      prev_vld          <= 1'b1;
      axiod             <= '0;
      axiov             <= 1'b0;
      kill              <= 1'b0;
      src_ip_out        <= '0;
      dst_ip_out        <= '0;
      protocol_out      <= '0;
      packet_length_out <= '0;
    end else begin
      prev_vld <= axiiv;
      axiov    <= 1'b0;
      axiod    <= '0;
      kill     <= 1'b0;
      if (!axiiv) begin
        if (state == PAYLOAD) kill <= 1'b1;
        state    <= IDLE;
        cnt      <= '0;
        acc      <= '0;
        pay_left <= '0;
      end else begin
        case (state)
          IDLE, HEADER: begin
            if (hdr_beat) begin
              hdr   <= hdr_nxt[159-N:0];
              cnt   <= cnt + 7'd1;
              state <= HEADER;
              if (word_end) acc <= acc_nxt;
              if (last_hdr) begin
                cnt <= '0;
                acc <= '0;
                if (hdr_ok) begin
                  src_ip_out        <= hdr_nxt.src;
                  dst_ip_out        <= hdr_nxt.dst;
                  protocol_out      <= hdr_nxt.protocol;
                  packet_length_out <= plen;
                  pay_left          <= beats;
                  state             <= (beats == 20'd0) ? DROP : PAYLOAD;
                end else begin
                  kill  <= 1'b1;
                  state <= DROP;
                end
              end
            end
          end
          PAYLOAD: begin
            axiov    <= 1'b1;
            axiod    <= axiid;
            pay_left <= pay_left - 20'd1;
            if (pay_left == 20'd1) state <= DROP;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
